// File: rtl/alu_op_sequencer_if.sv
// Host-side byte stream, ALU bus/strobes and result port of the ALU front-end sequencer.
// The sequencer uses the slave modport; the host/ALU environment uses master.
interface alu_op_sequencer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] i_in_data;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW+1:0] o_alu_data_bus;
  logic          o_load_A;
  logic          o_load_B;
  logic          o_load_op;
  logic          o_refresh;
  logic [DW-1:0] i_alu_result;
  logic [DW-1:0] o_res_data;
  logic          o_res_err;
  logic          o_res_valid;
  logic          i_res_ready;
  logic          o_timeout;

  modport slave (
    input  i_in_data, i_in_valid, i_alu_result, i_res_ready,
    output o_in_ready, o_alu_data_bus, o_load_A, o_load_B, o_load_op,
           o_refresh, o_res_data, o_res_err, o_res_valid, o_timeout
  );

  modport master (
    output i_in_data, i_in_valid, i_alu_result, i_res_ready,
    input  o_in_ready, o_alu_data_bus, o_load_A, o_load_B, o_load_op,
           o_refresh, o_res_data, o_res_err, o_res_valid, o_timeout
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences A, B and opcode bytes onto the ALU shared bus, pulses refresh and returns the result.
//   state  | meaning
//   S_A    | waiting for operand A
//   S_B    | waiting for operand B (timeout armed)
//   S_OP   | waiting for opcode (timeout armed)
//   S_EXEC | opcode loaded, issue refresh
//   S_WAIT | waiting out ALU latency
//   S_RESP | result held until consumer takes it
module alu_op_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MODE_WIDTH     = 6,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  alu_op_sequencer_if.slave bus_if
);
  localparam int BW      = DATA_WIDTH + 2;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > ALU_LATENCY) ? TIMEOUT_CYCLES : ALU_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bus_q, bus_d;
  logic                  load_a_q, load_a_d;
  logic                  load_b_q, load_b_d;
  logic                  load_op_q, load_op_d;
  logic                  refresh_q, refresh_d;
  logic                  timeout_q, timeout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic                  res_valid_q, res_valid_d;

  logic                  in_ready;
  logic                  accept;
  logic [MODE_WIDTH-1:0] op_field;

  function automatic logic op_is_valid(input logic [MODE_WIDTH-1:0] op);
    case (op)
      MODE_WIDTH'(6'b100000), MODE_WIDTH'(6'b100010), MODE_WIDTH'(6'b100100),
      MODE_WIDTH'(6'b100101), MODE_WIDTH'(6'b100110), MODE_WIDTH'(6'b100111),
      MODE_WIDTH'(6'b000011), MODE_WIDTH'(6'b000010): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign in_ready = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);
  assign accept   = bus_if.i_in_valid && in_ready;
  assign op_field = bus_if.i_in_data[MODE_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    load_op_d   = 1'b0;
    refresh_d   = 1'b0;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;

    case (state_q)
      S_A, S_B: begin
        if (accept) begin
          bus_d = {{2{bus_if.i_in_data[DATA_WIDTH-1]}}, bus_if.i_in_data};
          cnt_d = CW'(TIMEOUT_CYCLES - 1);
          if (state_q == S_A) begin
            load_a_d = 1'b1;
            state_d  = S_B;
          end else begin
            load_b_d = 1'b1;
            state_d  = S_OP;
          end
        end
      end
      S_OP: begin
        if (accept) begin
          bus_d = BW'(op_field);
          if (op_is_valid(op_field)) begin
            load_op_d = 1'b1;
            state_d   = S_EXEC;
          end else begin
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_EXEC: begin
        refresh_d = 1'b1;
        cnt_d     = CW'(ALU_LATENCY);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_data_d  = bus_if.i_alu_result;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (bus_if.i_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    // Idle gap between bytes of one transaction; an accept on the expiry edge wins.
    if ((TIMEOUT_CYCLES > 0) && ((state_q == S_B) || (state_q == S_OP)) && !accept) begin
      if (cnt_q == '0) begin
        timeout_d = 1'b1;
        state_d   = S_A;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_A;
      bus_q       <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      load_op_q   <= 1'b0;
      refresh_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      load_op_q   <= load_op_d;
      refresh_q   <= refresh_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus_if.o_in_ready     = in_ready;
  assign bus_if.o_alu_data_bus = bus_q;
  assign bus_if.o_load_A       = load_a_q;
  assign bus_if.o_load_B       = load_b_q;
  assign bus_if.o_load_op      = load_op_q;
  assign bus_if.o_refresh      = refresh_q;
  assign bus_if.o_timeout      = timeout_q;
  assign bus_if.o_res_data     = res_data_q;
  assign bus_if.o_res_err      = res_err_q;
  assign bus_if.o_res_valid    = res_valid_q;
endmodule
